nv_nvdla_cvif_client_wr_pack: RTL and testbench
===============================================

Name: nv_nvdla_cvif_client_wr_pack

Overview:
Client-side write packetizer that sits directly upstream of the CVIF write path, on one client port (sdp/cdp/pdp/bdma/rbk to cvif). It converts a command stream (addr, size, ack flag) plus a 512-bit data stream into the 515-bit wr_req packet stream. Each request becomes one command packet followed by its data packets. It also counts outstanding acknowledged writes against the per-client wr_rsp_complete pulse returned by CVIF.

Parameters:
ACK_W, 8, width of the outstanding-ack counter; at most 2^ACK_W-1 acked requests in flight.

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  64  byte address, 32B aligned; forwarded unmodified
cmd_size  in  13  number of 32B atoms minus 1
cmd_require_ack  in  1  request wants a completion pulse
dat_valid  in  1  data beat valid
dat_ready  out  1  data beat accepted when valid&ready
dat_data  in  512  two 32B atoms, atom0 in [255:0]
wr_req_valid  out  1  packet valid to CVIF
wr_req_ready  in  1  CVIF accepts packet
wr_req_pd  out  515  packet: [514]=pkt id (0 cmd, 1 data); cmd: [63:0] addr, [76:64] size, [77] require_ack, rest 0; data: [511:0] data, [513:512] mask
wr_rsp_complete  in  1  one-cycle pulse per completed acked request
ack_cnt  out  ACK_W  outstanding acked requests
wr_idle  out  1  no request in progress, no packet held, ack_cnt==0
err_rsp_underflow  out  1  sticky: complete received with ack_cnt==0

Behaviour:
- Reset (async assert, sync release): state=IDLE, wr_req_valid=0, wr_req_pd=0, beat_cnt=0, ack_cnt=0, err_rsp_underflow=0. After reset, cmd_ready is 1 and dat_ready is 0. wr_idle=1.
- Output stage: single register, valid/ready.
  - can_load = !wr_req_valid | wr_req_ready.
  - Latency is 1 cycle from input accept to wr_req_valid. Full throughput with back-to-back accepts.
  - pd is held stable while valid & !ready.
- FSM, two states:
  - IDLE: cmd_ready = can_load & (ack_cnt != max); dat_ready=0. On cmd accept: load cmd packet, beat_cnt = cmd_size[12:1], latch last_mask = cmd_size[0] ? 2'b11 : 2'b01, go to DATA.
  - DATA: cmd_ready=0; dat_ready=can_load. On each data accept: load data packet. Mask is 2'b11 when beat_cnt!=0, else last_mask.
  - In DATA, when beat_cnt==0 on accept, go to IDLE. Otherwise decrement beat_cnt.
- Beats per request = cmd_size[12:1]+1.
  - size=0: 1 beat, mask 01.
  - size=1: 1 beat, mask 11.
  - size=2: 2 beats, masks 11 then 01.
  - size=8191: 4096 beats, last mask 11.
- No bubble between requests: the cycle after the last data accept, IDLE can accept the next command.
- The ack gate applies to every command, not only acked ones.
- Ack counter:
  - +1 on cmd accept with require_ack=1.
  - -1 on wr_rsp_complete when ack_cnt>0.
  - Simultaneous +1 and -1 leaves the count unchanged.
  - Complete with ack_cnt==0: no change, set err_rsp_underflow. This includes a simultaneous increment from 0: the increment applies and the error is set.
- Data arriving in IDLE is not consumed (dat_ready=0). Commands are not consumed in DATA.
- wr_idle = (state==IDLE) & !wr_req_valid & (ack_cnt==0), combinational from registers.
- Reset mid-request: everything returns to its reset value immediately. A held packet is dropped. Partial requests are not resumed.

Test Plan:
- Reset, then cmd addr=0x1000, size=0, ack=1; 1 data beat; ready=1 -> cmd pd[514]=0, [63:0]=0x1000, [77]=1. Data pd[514]=1, mask=01. ack_cnt=1. A complete pulse then gives ack_cnt=0, wr_idle=1.
- size=4, ack=0; 3 data beats -> masks 11,11,01. State returns to IDLE. ack_cnt stays 0.
- Back-to-back size=1 requests with wr_req_ready toggling 1,0 each cycle -> pd stable while stalled. No packet lost or duplicated. Order: cmd, data, cmd, data.
- ACK_W=2: issue 3 acked cmds -> the 4th cmd is stalled (cmd_ready=0). A complete pulse reopens cmd_ready the following cycle.
- Complete pulse with ack_cnt=0 -> err_rsp_underflow=1 and stays set. A simultaneous acked cmd accept plus complete at ack_cnt=2 keeps ack_cnt=2.
- Assert reset during the beat 2 of 4 stall -> wr_req_valid=0 asynchronously, state IDLE, cmd_ready=1 after release.

Source files
------------

// File: rtl/nv_nvdla_cvif_client_wr_pack_if.sv
// Command / data / packet handshake bundle for one CVIF write client port.
interface nv_nvdla_cvif_client_wr_pack_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_addr;
    logic [12:0]  cmd_size;
    logic         cmd_require_ack;
    logic         dat_valid;
    logic         dat_ready;
    logic [511:0] dat_data;
    logic         wr_req_valid;
    logic         wr_req_ready;
    logic [514:0] wr_req_pd;

    // client side: produces commands and data, consumes packets
    modport master (
        output cmd_valid, cmd_addr, cmd_size, cmd_require_ack,
        input  cmd_ready,
        output dat_valid, dat_data,
        input  dat_ready,
        input  wr_req_valid, wr_req_pd,
        output wr_req_ready
    );

    // packer side
    modport slave (
        input  cmd_valid, cmd_addr, cmd_size, cmd_require_ack,
        output cmd_ready,
        input  dat_valid, dat_data,
        output dat_ready,
        output wr_req_valid, wr_req_pd,
        input  wr_req_ready
    );
endinterface

// File: rtl/nv_nvdla_cvif_client_wr_pack.sv
// Client write packetizer: one command packet followed by its data packets,
// through a single-entry output register, plus outstanding-ack accounting.
module nv_nvdla_cvif_client_wr_pack #(
    parameter int ACK_W = 8
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    nv_nvdla_cvif_client_wr_pack_if.slave wr_if,
    input  logic                         wr_rsp_complete,
    output logic [ACK_W-1:0]             ack_cnt,
    output logic                         wr_idle,
    output logic                         err_rsp_underflow
);

    localparam logic [ACK_W-1:0] ACK_ONE = ACK_W'(1);
    localparam logic [ACK_W-1:0] ACK_MAX = '1;

    typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

    state_t       state, state_nxt;
    logic [11:0]  beat_cnt, beat_cnt_nxt;
    logic [1:0]   last_mask, last_mask_nxt;
    logic         req_valid;
    logic [514:0] req_pd;
    logic         can_load;
    logic         cmd_ready, dat_ready;
    logic         cmd_acc, dat_acc, ack_inc;

    // the output register can take a new packet when empty or draining this cycle
    assign can_load = !req_valid || wr_if.wr_req_ready;
    assign cmd_acc  = wr_if.cmd_valid && cmd_ready;
    assign dat_acc  = wr_if.dat_valid && dat_ready;
    assign ack_inc  = cmd_acc && wr_if.cmd_require_ack;

    assign wr_if.cmd_ready    = cmd_ready;
    assign wr_if.dat_ready    = dat_ready;
    assign wr_if.wr_req_valid = req_valid;
    assign wr_if.wr_req_pd    = req_pd;

    assign wr_idle = (state == IDLE) && !req_valid && (ack_cnt == '0);

    // state register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            last_mask <= 2'b01;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            last_mask <= last_mask_nxt;
        end
    end

    // next state and handshake readies; a full ack counter gates every command
    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        last_mask_nxt = last_mask;
        cmd_ready     = 1'b0;
        dat_ready     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = can_load && (ack_cnt != ACK_MAX);
                if (wr_if.cmd_valid && cmd_ready) begin
                    beat_cnt_nxt  = wr_if.cmd_size[12:1];
                    last_mask_nxt = wr_if.cmd_size[0] ? 2'b11 : 2'b01;
                    state_nxt     = DATA;
                end
            end
            DATA: begin
                dat_ready = can_load;
                if (wr_if.dat_valid && dat_ready) begin
                    if (beat_cnt == '0) state_nxt = IDLE;
                    else                beat_cnt_nxt = beat_cnt - 12'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output packet register; pd holds while stalled, only the valid drops on drain
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            req_valid <= 1'b0;
            req_pd    <= '0;
        end else if (cmd_acc) begin
            req_valid <= 1'b1;
            req_pd    <= {1'b0, 436'b0, wr_if.cmd_require_ack, wr_if.cmd_size, wr_if.cmd_addr};
        end else if (dat_acc) begin
            req_valid <= 1'b1;
            req_pd    <= {1'b1, (beat_cnt != '0) ? 2'b11 : last_mask, wr_if.dat_data};
        end else if (can_load) begin
            req_valid <= 1'b0;
        end
    end

    // outstanding acked writes; a completion with nothing outstanding is flagged, not counted
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            ack_cnt           <= '0;
            err_rsp_underflow <= 1'b0;
        end else if (wr_rsp_complete && (ack_cnt == '0)) begin
            err_rsp_underflow <= 1'b1;
            if (ack_inc) ack_cnt <= ack_cnt + ACK_ONE;
        end else if (wr_rsp_complete && !ack_inc) begin
            ack_cnt <= ack_cnt - ACK_ONE;
        end else if (!wr_rsp_complete && ack_inc) begin
            ack_cnt <= ack_cnt + ACK_ONE;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cvif_client_wr_pack.sv
// Randomized bench for the client write packer. The reference model tracks
// per-request beats remaining, the expected packet stream and the ack count.
module tb_nv_nvdla_cvif_client_wr_pack;
    localparam int ACK_W = 2;
    localparam int MAXC  = (1 << ACK_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nv_nvdla_cvif_client_wr_pack_if bus();
    logic             rsp;
    logic [ACK_W-1:0] ack_cnt;
    logic             wr_idle;
    logic             err;

    nv_nvdla_cvif_client_wr_pack #(.ACK_W(ACK_W)) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .wr_if             (bus),
        .wr_rsp_complete   (rsp),
        .ack_cnt           (ack_cnt),
        .wr_idle           (wr_idle),
        .err_rsp_underflow (err)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [12:0] size;
        logic        ack;
    } cmd_t;

    cmd_t         pend[$];
    logic [514:0] exp_q[$];
    int           checks = 0;
    int           fails  = 0;
    int           rem, cnt, data_left, pkt_cnt, run_cycles;
    logic [12:0]  cur_size;
    bit           err_m, held, last_cacc, last_dacc;
    logic [514:0] held_pd;

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_require_ack = 0;
        bus.dat_valid = 0; bus.dat_data = '0; bus.wr_req_ready = 1; rsp = 0;
    endtask

    task automatic model_reset();
        rem = 0; cnt = 0; err_m = 0; held = 0; last_cacc = 0; last_dacc = 0;
        data_left = 0; exp_q.delete(); pend.delete();
    endtask

    task automatic push_cmd(input logic [63:0] a, input logic [12:0] s, input logic k);
        cmd_t c;
        c.addr = a; c.size = s; c.ack = k;
        pend.push_back(c);
        data_left += int'(s[12:1]) + 1;
    endtask

    // one clock: check everything against the model at the negedge, then advance it
    task automatic cycle();
        bit can, cacc, dacc, oacc, exp_cr, exp_dr, exp_idle;
        logic [1:0]   m;
        logic [514:0] e;
        @(negedge clk);
        can      = (exp_q.size() == 0) || bus.wr_req_ready;
        exp_cr   = (rem == 0) && can && (cnt != MAXC);
        exp_dr   = (rem != 0) && can;
        exp_idle = (rem == 0) && (exp_q.size() == 0) && (cnt == 0);
        checks++; if (bus.wr_req_valid !== (exp_q.size() != 0)) begin fails++;
            $display("FAIL wr_req_valid: got %b exp %b", bus.wr_req_valid, exp_q.size() != 0); end
        checks++; if (bus.cmd_ready !== exp_cr) begin fails++;
            $display("FAIL cmd_ready: got %b exp %b", bus.cmd_ready, exp_cr); end
        checks++; if (bus.dat_ready !== exp_dr) begin fails++;
            $display("FAIL dat_ready: got %b exp %b", bus.dat_ready, exp_dr); end
        checks++; if (ack_cnt !== ACK_W'(cnt)) begin fails++;
            $display("FAIL ack_cnt: got %0d exp %0d", ack_cnt, cnt); end
        checks++; if (err !== err_m) begin fails++;
            $display("FAIL err_rsp_underflow: got %b exp %b", err, err_m); end
        checks++; if (wr_idle !== exp_idle) begin fails++;
            $display("FAIL wr_idle: got %b exp %b", wr_idle, exp_idle); end
        if (held) begin
            checks++; if (bus.wr_req_valid !== 1'b1 || bus.wr_req_pd !== held_pd) begin fails++;
                $display("FAIL stall_hold: got v=%b pd=%h exp pd=%h", bus.wr_req_valid, bus.wr_req_pd, held_pd); end
        end
        oacc = bus.wr_req_valid && bus.wr_req_ready;
        if (oacc) begin
            pkt_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.wr_req_pd !== e) begin fails++;
                    $display("FAIL pkt: got %h exp %h", bus.wr_req_pd, e); end
            end
        end
        held    = bus.wr_req_valid && !bus.wr_req_ready;
        held_pd = bus.wr_req_pd;
        cacc = bus.cmd_valid && bus.cmd_ready;
        dacc = bus.dat_valid && bus.dat_ready;
        if (cacc) begin
            e = '0;
            e[63:0]  = bus.cmd_addr;
            e[76:64] = bus.cmd_size;
            e[77]    = bus.cmd_require_ack;
            exp_q.push_back(e);
            rem      = int'(bus.cmd_size) / 2 + 1;
            cur_size = bus.cmd_size;
        end
        if (dacc && rem > 0) begin
            m = (rem > 1 || cur_size[0]) ? 2'b11 : 2'b01;
            exp_q.push_back({1'b1, m, bus.dat_data});
            rem--;
        end
        if (rsp) begin
            if (cnt == 0) begin err_m = 1; cnt += (cacc && bus.cmd_require_ack) ? 1 : 0; end
            else cnt += (cacc && bus.cmd_require_ack) ? 0 : -1;
        end else if (cacc && bus.cmd_require_ack) cnt++;
        last_cacc = cacc;
        last_dacc = dacc;
        @(posedge clk); #1;
    endtask

    // drain pending commands and their data with random handshake pressure
    task automatic run(input int vpct, input int rdy_mode, input int rsp_pct, input int budget);
        cmd_t c;
        run_cycles = 0;
        while (!(pend.size() == 0 && !bus.cmd_valid && data_left == 0 && !bus.dat_valid &&
                 exp_q.size() == 0 && !(rsp_pct > 0 && cnt > 0))) begin
            if (run_cycles >= budget) begin
                checks++; fails++;
                $display("FAIL run_timeout: got %0d cycles exp under %0d", run_cycles, budget);
                break;
            end
            if (last_cacc || !bus.cmd_valid) begin
                bus.cmd_valid = 0;
                if (pend.size() > 0 && $urandom_range(99) < vpct) begin
                    c = pend.pop_front();
                    bus.cmd_valid = 1; bus.cmd_addr = c.addr; bus.cmd_size = c.size;
                    bus.cmd_require_ack = c.ack;
                end
            end
            if (last_dacc || !bus.dat_valid) begin
                bus.dat_valid = 0;
                if (data_left > 0 && $urandom_range(99) < vpct) begin
                    bus.dat_valid = 1; bus.dat_data = rnd512(); data_left--;
                end
            end
            case (rdy_mode)
                0:       bus.wr_req_ready = 1;
                1:       bus.wr_req_ready = run_cycles[0];
                default: bus.wr_req_ready = ($urandom_range(99) < 60);
            endcase
            rsp = (cnt > 0) && ($urandom_range(99) < rsp_pct);
            cycle();
            run_cycles++;
        end
        bus.cmd_valid = 0; bus.dat_valid = 0; bus.wr_req_ready = 1; rsp = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #12;
        checks++; if (bus.wr_req_valid !== 1'b0 || bus.wr_req_pd !== '0) begin fails++;
            $display("FAIL reset_out: got v=%b pd=%h exp 0", bus.wr_req_valid, bus.wr_req_pd); end
        checks++; if (bus.cmd_ready !== 1'b1 || bus.dat_ready !== 1'b0) begin fails++;
            $display("FAIL reset_ready: got cr=%b dr=%b exp 1 0", bus.cmd_ready, bus.dat_ready); end
        checks++; if (ack_cnt !== '0 || err !== 1'b0 || wr_idle !== 1'b1) begin fails++;
            $display("FAIL reset_status: got ack=%0d err=%b idle=%b exp 0 0 1", ack_cnt, err, wr_idle); end
        @(posedge clk); #1 rst = 0;
        cycle();
    endtask

    task automatic test_single();
        push_cmd(64'h1000, 13'd0, 1'b1);
        run(100, 0, 0, 50);
        checks++; if (ack_cnt !== 2'd1) begin fails++;
            $display("FAIL single_ack: got %0d exp 1", ack_cnt); end
        rsp = 1; cycle(); rsp = 0; cycle();
        checks++; if (ack_cnt !== 2'd0 || wr_idle !== 1'b1) begin fails++;
            $display("FAIL single_done: got ack=%0d idle=%b exp 0 1", ack_cnt, wr_idle); end
    endtask

    task automatic test_multi_beat();
        int p0 = pkt_cnt;
        push_cmd(64'h2_0000_0040, 13'd4, 1'b0);
        run(100, 0, 0, 50);
        checks++; if (pkt_cnt - p0 !== 4) begin fails++;
            $display("FAIL multi_pkts: got %0d exp 4", pkt_cnt - p0); end
        checks++; if (ack_cnt !== 2'd0 || wr_idle !== 1'b1) begin fails++;
            $display("FAIL multi_idle: got ack=%0d idle=%b exp 0 1", ack_cnt, wr_idle); end
    endtask

    task automatic test_sizes();
        int p0 = pkt_cnt;
        push_cmd(64'h100, 13'd0, 1'b0);
        push_cmd(64'h200, 13'd1, 1'b0);
        push_cmd(64'h300, 13'd2, 1'b0);
        push_cmd(64'h400, 13'd3, 1'b0);
        push_cmd(64'hFFFF_FFFF_FFFF_FFE0, 13'd8191, 1'b0);
        run(100, 2, 0, 15000);
        checks++; if (pkt_cnt - p0 !== 5 + 1 + 1 + 2 + 2 + 4096) begin fails++;
            $display("FAIL sizes_pkts: got %0d exp %0d", pkt_cnt - p0, 5 + 1 + 1 + 2 + 2 + 4096); end
    endtask

    task automatic test_back_to_back();
        int p0;
        for (int i = 0; i < 4; i++) push_cmd({$urandom, $urandom_range(1023), 5'b0}, 13'd1, 1'b0);
        run(100, 0, 0, 50);
        checks++; if (run_cycles !== 9) begin fails++;
            $display("FAIL b2b_throughput: got %0d cycles exp 9", run_cycles); end
        p0 = pkt_cnt;
        for (int i = 0; i < 6; i++) push_cmd({$urandom, $urandom_range(1023), 5'b0}, 13'd1, 1'b0);
        run(100, 1, 0, 100);
        checks++; if (pkt_cnt - p0 !== 12) begin fails++;
            $display("FAIL b2b_toggle_pkts: got %0d exp 12", pkt_cnt - p0); end
    endtask

    task automatic test_ack_gate();
        for (int i = 0; i < 3; i++) push_cmd(64'h4000 + 64'(i * 32), 13'd0, 1'b1);
        run(100, 0, 0, 50);
        checks++; if (ack_cnt !== 2'd3) begin fails++;
            $display("FAIL gate_full: got %0d exp 3", ack_cnt); end
        bus.cmd_valid = 1; bus.cmd_addr = 64'h5000; bus.cmd_size = 0; bus.cmd_require_ack = 0;
        data_left += 1;
        cycle(); cycle(); cycle();
        checks++; if (last_cacc !== 1'b0) begin fails++;
            $display("FAIL gate_stall: got accept=%b exp 0", last_cacc); end
        rsp = 1; cycle(); rsp = 0;
        checks++; if (last_cacc !== 1'b0) begin fails++;
            $display("FAIL gate_pulse_cycle: got accept=%b exp 0", last_cacc); end
        cycle();
        checks++; if (last_cacc !== 1'b1) begin fails++;
            $display("FAIL gate_reopen: got accept=%b exp 1", last_cacc); end
        run(100, 0, 100, 100);
    endtask

    task automatic test_underflow();
        rsp = 1; cycle(); rsp = 0; cycle(); cycle();
        checks++; if (err !== 1'b1) begin fails++;
            $display("FAIL underflow_sticky: got %b exp 1", err); end
        push_cmd(64'h6000, 13'd0, 1'b1);
        push_cmd(64'h6020, 13'd0, 1'b1);
        run(100, 0, 0, 50);
        bus.cmd_valid = 1; bus.cmd_addr = 64'h6040; bus.cmd_size = 0; bus.cmd_require_ack = 1;
        data_left += 1;
        rsp = 1; cycle(); rsp = 0; bus.cmd_valid = 0;
        cycle();
        checks++; if (ack_cnt !== 2'd2) begin fails++;
            $display("FAIL simul_inc_dec: got %0d exp 2", ack_cnt); end
        run(100, 0, 100, 100);
        bus.cmd_valid = 1; bus.cmd_addr = 64'h6060; bus.cmd_size = 0; bus.cmd_require_ack = 1;
        data_left += 1;
        rsp = 1; cycle(); rsp = 0; bus.cmd_valid = 0;
        cycle();
        checks++; if (ack_cnt !== 2'd1 || err !== 1'b1) begin fails++;
            $display("FAIL underflow_with_inc: got ack=%0d err=%b exp 1 1", ack_cnt, err); end
        run(100, 0, 100, 100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            push_cmd({$urandom, $urandom_range(4095), 5'b0}, 13'($urandom_range(15)), 1'($urandom_range(1)));
        run(70, 2, 30, 4000);
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1; bus.cmd_addr = 64'h7000; bus.cmd_size = 13'd6; bus.cmd_require_ack = 1;
        bus.wr_req_ready = 1; bus.dat_valid = 1; bus.dat_data = rnd512();
        cycle();
        bus.cmd_valid = 0;
        cycle();
        bus.dat_data = rnd512();
        cycle();
        bus.wr_req_ready = 0; bus.dat_data = rnd512();
        cycle();
        checks++; if (bus.wr_req_valid !== 1'b1 || bus.wr_req_pd[514] !== 1'b1) begin fails++;
            $display("FAIL mid_held: got v=%b id=%b exp 1 1", bus.wr_req_valid, bus.wr_req_pd[514]); end
        #2 rst = 1;
        #1;
        checks++; if (bus.wr_req_valid !== 1'b0 || bus.wr_req_pd !== '0 || ack_cnt !== '0) begin fails++;
            $display("FAIL mid_async: got v=%b ack=%0d exp 0 0", bus.wr_req_valid, ack_cnt); end
        idle_inputs();
        model_reset();
        @(posedge clk); #1 rst = 0;
        cycle();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.dat_ready !== 1'b0 || wr_idle !== 1'b1) begin fails++;
            $display("FAIL mid_release: got cr=%b dr=%b idle=%b exp 1 0 1", bus.cmd_ready, bus.dat_ready, wr_idle); end
        push_cmd(64'h8000, 13'd3, 1'b0);
        run(100, 2, 0, 100);
    endtask

    initial begin
        pkt_cnt = 0;
        test_reset();
        test_single();
        test_multi_beat();
        test_sizes();
        test_back_to_back();
        test_ack_gate();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
